v_lane_seq: RTL



---
 rtl/v_lane_seq.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/v_lane_seq.sv
// v_lane_seq: per-lane element sequencer for a banked vector register file.
//
// Accepts one vector-scalar command (vl, op, scalar). Each RUN step reads
// one element per lane. Lane i reads element k*lanes_p + i at step k. The
// block applies op(elem, scalar) and writes the result back in place one
// cycle later. Writes for step k overlap the reads for step k+1.
//
// Ports:
//   clk_i     - clock, rising edge
//   reset_i   - asynchronous active-high reset
//   v_i       - command valid; only sampled while ready_o = 1
//   ready_o   - high in IDLE only
//   vl_i      - active element count; clamped to vlen_p
//   op_i      - 00 pass, 01 add, 10 subtract, 11 xor (with scalar)
//   scalar_i  - scalar operand, captured when the command is accepted
//   r_addr_o  - per-lane read element index (0 when not reading)
//   r_data_i  - per-lane read data, combinational from r_addr_o
//   w_addr_o  - per-lane write element index
//   w_data_o  - per-lane write data
//   w_en_o    - per-lane write enable
//   done_o    - one-cycle pulse in the cycle carrying the last write
module v_lane_seq #(
    parameter int vlen_p  = 8,
    parameter int vdw_p   = 32,
    parameter int lanes_p = 4,
    localparam int addr_width_lp = (vlen_p > 1) ? $clog2(vlen_p) : 1,
    localparam int vl_width_lp   = (vlen_p + 1 > 1) ? $clog2(vlen_p + 1) : 1
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   v_i,
    output logic                                   ready_o,
    input  logic [vl_width_lp-1:0]                 vl_i,
    input  logic [1:0]                             op_i,
    input  logic [vdw_p-1:0]                       scalar_i,
    output logic [lanes_p-1:0][addr_width_lp-1:0]  r_addr_o,
    input  logic [lanes_p-1:0][vdw_p-1:0]          r_data_i,
    output logic [lanes_p-1:0][addr_width_lp-1:0]  w_addr_o,
    output logic [lanes_p-1:0][vdw_p-1:0]          w_data_o,
    output logic [lanes_p-1:0]                     w_en_o,
    output logic                                   done_o
);

    localparam int steps_lp      = vlen_p / lanes_p;
    localparam int step_width_lp = (steps_lp > 1) ? $clog2(steps_lp) : 1;
    // One extra bit so (k+1)*lanes_p and vl compare without overflow.
    localparam int idx_width_lp  = vl_width_lp + 1;
    localparam logic [vl_width_lp-1:0] vlen_lp = vl_width_lp'(vlen_p);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_e;

    state_e                                  state_q;
    logic [step_width_lp-1:0]                step_q;
    logic [vl_width_lp-1:0]                  vl_q;
    logic [1:0]                              op_q;
    logic [vdw_p-1:0]                        scalar_q;
    logic [lanes_p-1:0]                      w_en_q;
    logic [lanes_p-1:0][addr_width_lp-1:0]   w_addr_q;
    logic [lanes_p-1:0][vdw_p-1:0]           w_data_q;
    logic                                    done_q;
    logic                                    ready_q;

    logic [vl_width_lp-1:0]                  vl_clamped;
    logic [lanes_p-1:0][idx_width_lp-1:0]    elem_idx;
    logic [lanes_p-1:0]                      lane_active;
    logic [lanes_p-1:0][vdw_p-1:0]           lane_result;
    logic                                    last_step;

    assign vl_clamped = (vl_i > vlen_lp) ? vlen_lp : vl_i;

    // The step is final once the next step would start at or beyond vl.
    assign last_step = ((idx_width_lp'(step_q) + idx_width_lp'(1)) * idx_width_lp'(lanes_p))
                       >= {1'b0, vl_q};

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        elem_idx    = '0;
        lane_active = '0;
        lane_result = '0;
        r_addr_o    = '0;
        for (int i = 0; i < lanes_p; i++) begin
            elem_idx[i]    = idx_width_lp'(step_q) * idx_width_lp'(lanes_p) + idx_width_lp'(i);
            lane_active[i] = elem_idx[i] < {1'b0, vl_q};
            case (op_q)
                2'b00:   lane_result[i] = r_data_i[i];
                2'b01:   lane_result[i] = r_data_i[i] + scalar_q;
                2'b10:   lane_result[i] = r_data_i[i] - scalar_q;
                default: lane_result[i] = r_data_i[i] ^ scalar_q;
            endcase
            // Inactive lanes still read, so the address pattern is fixed per step.
            if (state_q == S_RUN) begin
                r_addr_o[i] = addr_width_lp'(elem_idx[i]);
            end
        end
    end

    // NOTE: the datapath registers are reset too. They are few and drive outputs,
    // so the outputs read as zero straight out of reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            step_q   <= '0;
            vl_q     <= '0;
            op_q     <= '0;
            scalar_q <= '0;
            w_en_q   <= '0;
            w_addr_q <= '0;
            w_data_q <= '0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments throughout. Every register samples
            // pre-edge values, and the defaults below are overridden later in
            // the same block.
            w_en_q   <= '0;
            w_addr_q <= '0;
            w_data_q <= '0;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (v_i) begin
                        vl_q     <= vl_clamped;
                        op_q     <= op_i;
                        scalar_q <= scalar_i;
                        step_q   <= '0;
                        ready_q  <= 1'b0;
                        if (vl_clamped == '0) begin
                            // Empty command: go straight to the completion cycle.
                            state_q <= S_DRAIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    w_en_q <= lane_active;
                    for (int i = 0; i < lanes_p; i++) begin
                        w_addr_q[i] <= addr_width_lp'(elem_idx[i]);
                    end
                    w_data_q <= lane_result;
                    step_q   <= step_q + 1'b1;
                    if (last_step) begin
                        state_q <= S_DRAIN;
                        done_q  <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o  = ready_q;
    assign done_o   = done_q;
    assign w_en_o   = w_en_q;
    assign w_addr_o = w_addr_q;
    assign w_data_o = w_data_q;

endmodule
